// File: rtl/pic_bus_pkg.sv
// Shared types and timing defaults for the 8259 PIC host bus master.
// Imported by the FSM top and its phase timer.
package pic_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_ACK1,
    ST_GAP,
    ST_ACK2,
    ST_ACK_END
  } state_e;

  localparam int unsigned DEF_SETUP_CYCLES = 1;
  localparam int unsigned DEF_PULSE_CYCLES = 2;
  localparam int unsigned DEF_GAP_CYCLES   = 2;

  localparam logic [7:0] BUS_IDLE = 8'hZZ;

  typedef struct packed {
    logic       read;
    logic       a0;
    logic [7:0] wdata;
  } cmd_t;

  function automatic logic [3:0] phase_load(input int unsigned n);
    return 4'(n - 1);
  endfunction

endpackage

// File: rtl/pic_phase_timer.sv
// Loadable 4-bit down-counter timing each bus phase.
// done is high while the count sits at zero.
module pic_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] value,
  output logic       done
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/pic_host_bus_master.sv
// CPU-side initiator for the 8259 bus: timed register accesses
// plus autonomous two-pulse INTA vector fetch.
module pic_host_bus_master
  import pic_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       ack_enable,
  input  logic       INT,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  output logic       chip_select,
  output logic       write_flag,
  output logic       read_flag,
  output logic       INTA,
  output logic       A0,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in
);

  state_e     state_q;
  state_e     state_d;
  cmd_t       cmd_q;
  logic       tmr_load;
  logic [3:0] tmr_val;
  logic       tmr_done;
  logic       int_req;
  logic       in_acc;
  logic       in_strobe;

  assign int_req = ack_enable && INT;

  pic_phase_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_val),
    .done  (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (int_req) begin
          state_d = ST_ACK1;
        end else if (cmd_valid) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP:   if (tmr_done) state_d = ST_STROBE;
      ST_STROBE:  if (tmr_done) state_d = ST_HOLD;
      ST_HOLD:    state_d = ST_IDLE;
      ST_ACK1:    if (tmr_done) state_d = ST_GAP;
      ST_GAP:     if (tmr_done) state_d = ST_ACK2;
      ST_ACK2:    if (tmr_done) state_d = ST_ACK_END;
      ST_ACK_END: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Timer is reloaded only on a state change, with the length of the state being entered.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = 4'd0;
    unique case (state_d)
      ST_SETUP:  tmr_val = phase_load(SETUP_CYCLES);
      ST_STROBE: tmr_val = phase_load(PULSE_CYCLES);
      ST_ACK1:   tmr_val = phase_load(PULSE_CYCLES);
      ST_GAP:    tmr_val = phase_load(GAP_CYCLES);
      ST_ACK2:   tmr_val = phase_load(PULSE_CYCLES);
      default:   tmr_val = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      rsp_rdata <= 8'h00;
      vec_data  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && state_d == ST_SETUP) begin
        cmd_q <= '{read: cmd_read, a0: cmd_a0, wdata: cmd_wdata};
      end
      if (state_q == ST_STROBE && tmr_done && cmd_q.read) begin
        rsp_rdata <= data_in;
      end
      if (state_q == ST_ACK2 && tmr_done) begin
        vec_data <= data_in;
      end
    end
  end

  // Bus pins decode straight from state so an async reset idles them at once.
  assign in_acc    = (state_q == ST_SETUP) ||
                     (state_q == ST_STROBE) ||
                     (state_q == ST_HOLD);
  assign in_strobe = (state_q == ST_STROBE);

  assign chip_select = !in_acc;
  assign A0          = in_acc && cmd_q.a0;
  assign data_oe     = in_acc && !cmd_q.read;
  assign data_out    = data_oe ? cmd_q.wdata : 8'h00;
  assign write_flag  = !(in_strobe && !cmd_q.read);
  assign read_flag   = !(in_strobe && cmd_q.read);
  assign INTA        = !((state_q == ST_ACK1) || (state_q == ST_ACK2));
  assign rsp_valid   = (state_q == ST_HOLD) && cmd_q.read;
  assign vec_valid   = (state_q == ST_ACK_END);
  assign cmd_ready   = (state_q == ST_IDLE) && !int_req && !reset;

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Bench for pic_host_bus_master: queue-of-cycles reference model,
// directed test-plan scenarios and a randomized run.
module tb_pic_host_bus_master;

  localparam int S = 1;
  localparam int P = 2;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_read = 1'b0;
  logic       cmd_a0 = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       ack_enable = 1'b0;
  logic       intr = 1'b0;
  logic       vec_valid;
  logic [7:0] vec_data;
  logic       chip_select;
  logic       write_flag;
  logic       read_flag;
  logic       INTA;
  logic       A0;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in = 8'h00;

  always #5 clk = ~clk;

  pic_host_bus_master #(
    .SETUP_CYCLES (S),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_read    (cmd_read),
    .cmd_a0      (cmd_a0),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .ack_enable  (ack_enable),
    .INT         (intr),
    .vec_valid   (vec_valid),
    .vec_data    (vec_data),
    .chip_select (chip_select),
    .write_flag  (write_flag),
    .read_flag   (read_flag),
    .INTA        (INTA),
    .A0          (A0),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .data_in     (data_in)
  );

  typedef struct packed {
    logic       cs;
    logic       wr;
    logic       rd;
    logic       inta;
    logic       a0;
    logic [7:0] dout;
    logic       oe;
    logic       rv;
    logic       vv;
    logic [1:0] samp;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] m_vec = 8'h00;
  int         checks = 0;
  int         errors = 0;

  int n, cs_low, wr_low, rd_low, inta_low, oe_cnt;
  int rsp_cnt, vec_cnt, first_cs, last_cs, first_wr, first_inta;
  logic [7:0] rsp_last, vec_last;
  logic prev_cs;
  logic last_acc;
  logic a0_log[$];
  int   acc_log[$];

  function automatic exp_t mk(logic cs, logic wr, logic rd, logic inta,
                              logic a0, logic [7:0] dout, logic oe,
                              logic rv, logic vv, logic [1:0] samp);
    exp_t e;
    e = '{cs: cs, wr: wr, rd: rd, inta: inta, a0: a0, dout: dout,
          oe: oe, rv: rv, vv: vv, samp: samp};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic push_access(input logic rd, input logic a0,
                             input logic [7:0] wd);
    logic [7:0] d;
    d = rd ? 8'h00 : wd;
    for (int i = 0; i < S; i++)
      q.push_back(mk(0, 1, 1, 1, a0, d, !rd, 0, 0, 2'd0));
    for (int i = 0; i < P; i++)
      q.push_back(mk(0, rd, !rd, 1, a0, d, !rd, 0, 0,
                     (i == P - 1 && rd) ? 2'd1 : 2'd0));
    q.push_back(mk(0, 1, 1, 1, a0, d, !rd, rd, 0, 2'd0));
  endtask

  task automatic push_inta();
    for (int i = 0; i < P; i++)
      q.push_back(mk(1, 1, 1, 0, 0, 8'h00, 0, 0, 0, 2'd0));
    for (int i = 0; i < G; i++)
      q.push_back(mk(1, 1, 1, 1, 0, 8'h00, 0, 0, 0, 2'd0));
    for (int i = 0; i < P; i++)
      q.push_back(mk(1, 1, 1, 0, 0, 8'h00, 0, 0, 0,
                     (i == P - 1) ? 2'd2 : 2'd0));
    q.push_back(mk(1, 1, 1, 1, 0, 8'h00, 0, 0, 1, 2'd0));
  endtask

  task automatic clear_stats();
    cs_low = 0; wr_low = 0; rd_low = 0; inta_low = 0; oe_cnt = 0;
    rsp_cnt = 0; vec_cnt = 0; first_cs = -1; last_cs = -1;
    first_wr = -1; first_inta = -1; rsp_last = 8'h00; vec_last = 8'h00;
    a0_log.delete(); acc_log.delete();
  endtask

  // One bus cycle: drive, compare against the model, then advance the model.
  task automatic cyc(input logic v, input logic rd, input logic a0,
                     input logic [7:0] wd, input logic ack,
                     input logic i, input logic [7:0] din);
    exp_t e;
    logic rdy;
    cmd_valid = v; cmd_read = rd; cmd_a0 = a0; cmd_wdata = wd;
    ack_enable = ack; intr = i; data_in = din;
    #1;
    if (q.size() != 0) begin
      e = q[0];
      rdy = 1'b0;
    end else begin
      e = mk(1, 1, 1, 1, 0, 8'h00, 0, 0, 0, 2'd0);
      rdy = !(ack && i);
    end
    chk("bus_pins",
        {chip_select, write_flag, read_flag, INTA, A0, data_out,
         data_oe, rsp_valid, vec_valid, cmd_ready},
        {e.cs, e.wr, e.rd, e.inta, e.a0, e.dout, e.oe, e.rv, e.vv, rdy});
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("vec_data", vec_data, m_vec);
    n++;
    if (!chip_select) begin
      cs_low++;
      if (first_cs < 0) first_cs = n;
      last_cs = n;
      if (prev_cs) a0_log.push_back(A0);
    end
    prev_cs = chip_select;
    if (!write_flag) begin
      wr_low++;
      if (first_wr < 0) first_wr = n;
    end
    if (!read_flag) rd_low++;
    if (!INTA) begin
      inta_low++;
      if (first_inta < 0) first_inta = n;
    end
    if (data_oe) oe_cnt++;
    if (rsp_valid) begin rsp_cnt++; rsp_last = rsp_rdata; end
    if (vec_valid) begin vec_cnt++; vec_last = vec_data; end
    last_acc = v && cmd_ready;
    if (last_acc) acc_log.push_back(n);
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.samp == 2'd1) m_rdata = din;
      if (e.samp == 2'd2) m_vec = din;
    end else if (ack && i) begin
      push_inta();
    end else if (v) begin
      push_access(rd, a0, wd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] wds[4];
    logic       a0s[4];
    int         idx;
    int         budget;
    logic       ir;
    n = 0;
    prev_cs = 1'b1;
    clear_stats();

    #2;
    chk("rst_cs", chip_select, 1);
    chk("rst_wr", write_flag, 1);
    chk("rst_rd", read_flag, 1);
    chk("rst_inta", INTA, 1);
    chk("rst_a0", A0, 0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_oe", data_oe, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_valids", {rsp_valid, vec_valid}, 2'b00);
    chk("rst_data", {rsp_rdata, vec_data}, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ICW1 write
    clear_stats();
    cyc(1, 0, 0, 8'h1B, 0, 0, 8'h00);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
    chk("icw1_cs_low", cs_low, 4);
    chk("icw1_wr_low", wr_low, 2);
    chk("icw1_wr_start", first_wr - first_cs, 1);
    chk("icw1_oe_cycles", oe_cnt, 4);

    // ICW2..OCW2 back to back with cmd_valid held
    clear_stats();
    wds[0] = 8'hF8; wds[1] = 8'h00; wds[2] = 8'h0F; wds[3] = 8'h00;
    a0s[0] = 1'b1;  a0s[1] = 1'b1;  a0s[2] = 1'b1;  a0s[3] = 1'b0;
    idx = 0;
    budget = 0;
    while (idx < 4 && budget < 100) begin
      cyc(1, 0, a0s[idx], wds[idx], 0, 0, 8'h00);
      if (last_acc) idx++;
      budget++;
    end
    chk("b2b_accepted", idx, 4);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
    chk("b2b_accesses", a0_log.size(), 4);
    if (a0_log.size() == 4)
      chk("b2b_a0_pattern",
          {a0_log[0], a0_log[1], a0_log[2], a0_log[3]}, 4'b1110);
    if (acc_log.size() == 4)
      for (int k = 1; k < 4; k++)
        chk("b2b_interval", acc_log[k] - acc_log[k-1], S + P + 2);

    // register read
    clear_stats();
    cyc(1, 1, 0, 8'h00, 0, 0, 8'hA5);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 8'h00, 0, 0, 8'hA5);
    chk("rd_strobe_low", rd_low, 2);
    chk("rd_oe_cycles", oe_cnt, 0);
    chk("rd_rsp_pulses", rsp_cnt, 1);
    chk("rd_rsp_data", rsp_last, 8'hA5);

    // INTA sequence, INT dropping right after it is seen
    clear_stats();
    cyc(0, 0, 0, 8'h00, 1, 1, 8'h11);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 8'h00, 1, 0, 8'hFC);
    chk("ack_inta_low", inta_low, 4);
    chk("ack_vec_pulses", vec_cnt, 1);
    chk("ack_vec_data", vec_last, 8'hFC);
    chk("ack_cs_low", cs_low, 0);

    // INT and command in the same IDLE cycle
    clear_stats();
    idx = 0;
    budget = 0;
    while (idx == 0 && budget < 30) begin
      cyc(1, 0, 1, 8'h3C, 1, budget == 0, 8'h42);
      if (last_acc) idx = 1;
      budget++;
    end
    chk("same_cycle_accepted", idx, 1);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 8'h00, 1, 0, 8'h42);
    chk("same_cycle_int_first",
        (first_inta >= 0) && (first_inta < first_cs), 1);
    chk("same_cycle_cs_low", cs_low, 4);

    // INT rising mid-write
    clear_stats();
    cyc(1, 0, 0, 8'h77, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00, 1, 0, 8'h00);
    budget = 0;
    while (first_inta < 0 && budget < 20) begin
      cyc(0, 0, 0, 8'h00, 1, 1, 8'h9E);
      budget++;
    end
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 8'h00, 1, 0, 8'h9E);
    chk("mid_write_cs_low", cs_low, 4);
    chk("mid_write_int_after",
        (first_inta >= 0) && (first_inta > last_cs), 1);
    chk("mid_write_vec", vec_last, 8'h9E);

    // reset during write strobe
    cyc(1, 0, 1, 8'h5A, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
    cmd_valid = 1'b0;
    #1;
    chk("pre_rst_wr_low", write_flag, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr", write_flag, 1);
    chk("mid_rst_cs", chip_select, 1);
    chk("mid_rst_oe", data_oe, 0);
    chk("mid_rst_valids", {rsp_valid, vec_valid}, 2'b00);
    chk("mid_rst_rdata", rsp_rdata, 8'h00);
    q.delete();
    m_rdata = 8'h00;
    m_vec = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1);
    prev_cs = chip_select;
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);

    // randomized traffic
    ir = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) ir = !ir;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 8'($urandom),
          $urandom_range(0, 3) != 0, ir, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
